// File: rtl/exe_muldiv_ctrl_if.sv
// Mul/div command and result bundle between the EXE stage and the sequencer.
interface exe_muldiv_ctrl_if #(
    parameter int WORD_LEN = 32
);
    logic                start;
    logic [1:0]          op;
    logic [WORD_LEN-1:0] operand_a;
    logic [WORD_LEN-1:0] operand_b;
    logic                flush;
    logic                stall;
    logic                done;
    logic                div_by_zero;
    logic [WORD_LEN-1:0] hi;
    logic [WORD_LEN-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// Radix-2 MULT/MULTU/DIV/DIVU sequencer for the EXE stage.
// Iterates on magnitudes, applies signs in FIX, then commits HI/LO.
module exe_muldiv_ctrl #(
    parameter int WORD_LEN = 32,
    parameter int CNT_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    exe_muldiv_ctrl_if.slave   mdu
);
    localparam int L = WORD_LEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*L-1:0]   acc_q;
    logic [L-1:0]     b_q;
    logic             sa_q;
    logic             neg_q;
    logic             is_div_q;
    logic [L-1:0]     hi_q;
    logic [L-1:0]     lo_q;
    logic             dbz_q;

    logic             ready;
    logic             busy;
    logic             accept;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [L-1:0]     a_mag;
    logic [L-1:0]     b_mag;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy   = (state_q == S_MUL) || (state_q == S_DIV) ||
                    (state_q == S_FIX);
    assign accept = mdu.start && ready && !mdu.flush;

    assign signed_op = !mdu.op[0];
    assign a_neg     = signed_op && mdu.operand_a[L-1];
    assign b_neg     = signed_op && mdu.operand_b[L-1];
    // Two's-complement negate of 0x80000000 yields 2^31 read as unsigned.
    assign a_mag = a_neg ? -mdu.operand_a : mdu.operand_a;
    assign b_mag = b_neg ? -mdu.operand_b : mdu.operand_b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}
    logic [L:0]     mul_sum;
    logic [2*L-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc_q[2*L-1:L]} +
                     {1'b0, (acc_q[0] ? b_q : {L{1'b0}})};
    assign mul_nxt = {mul_sum, acc_q[L-1:1]};

    // Restoring step: acc = {remainder, dividend/quotient shift reg}
    logic [L:0]     div_sh;
    logic           div_ge;
    logic [L-1:0]   div_rem;
    logic [2*L-1:0] div_nxt;
    assign div_sh  = {acc_q[2*L-1:L], acc_q[L-1]};
    assign div_ge  = div_sh >= {1'b0, b_q};
    assign div_rem = div_ge ? (div_sh[L-1:0] - b_q) : div_sh[L-1:0];
    assign div_nxt = {div_rem, acc_q[L-2:0], div_ge};

    logic [2*L-1:0] prod_neg;
    logic [L-1:0]   quo_neg;
    logic [L-1:0]   rem_neg;
    logic [L-1:0]   fix_hi;
    logic [L-1:0]   fix_lo;
    assign prod_neg = -acc_q;
    assign quo_neg  = -acc_q[L-1:0];
    assign rem_neg  = -acc_q[2*L-1:L];

    always_comb begin
        fix_hi = acc_q[2*L-1:L];
        fix_lo = acc_q[L-1:0];
        if (is_div_q) begin
            if (neg_q) fix_lo = quo_neg;
            if (sa_q)  fix_hi = rem_neg;
        end else if (neg_q) begin
            fix_hi = prod_neg[2*L-1:L];
            fix_lo = prod_neg[L-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        cnt_q    <= CNT_W'(L);
                        sa_q     <= a_neg;
                        neg_q    <= a_neg ^ b_neg;
                        is_div_q <= mdu.op[1];
                        if (!mdu.op[1]) begin
                            acc_q   <= {{L{1'b0}}, b_mag};
                            b_q     <= a_mag;
                            state_q <= S_MUL;
                        end else if (mdu.operand_b == '0) begin
                            hi_q    <= mdu.operand_a;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= {{L{1'b0}}, a_mag};
                            b_q     <= b_mag;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (mdu.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= (state_q == S_MUL) ? mul_nxt : div_nxt;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (mdu.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        if (is_div_q) dbz_q <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mdu.stall       = busy || accept;
    assign mdu.done        = (state_q == S_DONE);
    assign mdu.div_by_zero = dbz_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
endmodule
